// File: rtl/bcd_pkg.sv
// Shared types, widths and the BCD-to-one-hot decode helper for the digit decoder.
package bcd_pkg;

  localparam int BCD_W    = 4;
  localparam int ONEHOT_W = 10;
  localparam int BCD_MAX  = 9;

  typedef logic [BCD_W-1:0]    bcd_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  typedef struct packed {
    onehot_t onehot;
    logic    err;
  } dec_t;

  // Codes above BCD_MAX decode to an all-zero word with err raised.
  function automatic dec_t bcd2onehot(input bcd_t d);
    dec_t r;
    r.onehot = {ONEHOT_W{1'b0}};
    r.err    = 1'b0;
    if (d <= bcd_t'(BCD_MAX)) begin
      r.onehot = {{(ONEHOT_W-1){1'b0}}, 1'b1} << d;
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_fifo.sv
// DEPTH-entry FIFO of BCD digits with explicit pointer wrap, so DEPTH need not be a power of two.
module bcd_digit_fifo
  import bcd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  bcd_t wr_data,
  input  logic rd_en,
  output bcd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  bcd_t             mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == {CNT_W{1'b0}});
  // A full FIFO refuses the write even when a pop happens on the same edge.
  assign do_push = wr_en & ~full;
  assign do_pop  = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {BCD_W{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bcd_to_onehot_dec.sv
// Buffered BCD-to-one-hot decoder with valid/ready on both sides.
// Optional saturating illegal-code counter enabled by macro BCD_ERR_CNT_EN.
module bcd_to_onehot_dec
  import bcd_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_bcd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9:0]           out_onehot,
  output logic                 out_err
`ifdef BCD_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  bcd_t head;
  logic full;
  logic empty;
  dec_t dec;

  bcd_digit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_bcd),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign in_ready  = ~full;
  assign out_valid = ~empty;

  // Decode the head entry; an empty FIFO presents an all-zero word.
  always_comb begin
    dec = bcd2onehot(head);
    if (empty) begin
      out_onehot = {ONEHOT_W{1'b0}};
      out_err    = 1'b0;
    end else begin
      out_onehot = dec.onehot;
      out_err    = dec.err;
    end
  end

`ifdef BCD_ERR_CNT_EN
  // Count popped illegal codes, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= {ERR_CNT_W{1'b0}};
    end else if (out_valid && out_ready && out_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end else begin
      err_cnt <= err_cnt;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^ERR_CNT_W;
`endif

endmodule
